// File: rtl/cora_mic_pkg.sv
// Shared sizing defaults and FSM state encoding for the microphone frame controller.
package cora_mic_pkg;

  localparam int FRAME_LEN_DEF  = 64;
  localparam int FIFO_DEPTH_DEF = 128;
  localparam int SAMPLE_W       = 16;
  localparam int LEVEL_W        = 8;
  localparam int DROP_W         = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAIT = 3'd1,
    RD   = 3'd2,
    LOAD = 3'd3,
    HOLD = 3'd4
  } frame_state_t;

endpackage

// File: rtl/mic_frame_occ.sv
// Tracks occupancy of the external sample FIFO and accounts for samples dropped
// because the FIFO was full.
module mic_frame_occ
  import cora_mic_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr,
  input  logic               rd,
  input  logic               drop,
  input  logic               ovf_clr,
  output logic [LEVEL_W-1:0] level,
  output logic               ovf,
  output logic [DROP_W-1:0]  drop_cnt
);

  localparam logic [LEVEL_W-1:0] DEPTH_L = LEVEL_W'(FIFO_DEPTH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level <= '0;
    end else if (wr && !rd && level != DEPTH_L) begin
      level <= level + 1'b1;
    end else if (rd && !wr && level != '0) begin
      level <= level - 1'b1;
    end
  end

  // A drop coinciding with a clear restarts the count at one instead of zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      ovf <= 1'b1;
      if (ovf_clr)
        drop_cnt <= DROP_W'(1);
      else if (drop_cnt != '1)
        drop_cnt <= drop_cnt + 1'b1;
    end else if (ovf_clr) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end
  end

endmodule

// File: rtl/mic_frame_ctrl.sv
// Captures PCM samples into an external FIFO and streams them out in frames of
// FRAME_LEN samples over a valid/ready handshake.
//
// state | meaning
// IDLE  | capture disabled, no frame in progress
// WAIT  | enabled, waiting for a full frame worth of samples in the FIFO
// RD    | issue one FIFO read (stalls while the FIFO reports empty)
// LOAD  | FIFO read data arrives, latch into the output register
// HOLD  | present the sample until the consumer accepts it
module mic_frame_ctrl
  import cora_mic_pkg::*;
#(
  parameter int FRAME_LEN  = FRAME_LEN_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                mic_valid,
  input  logic [SAMPLE_W-1:0] mic_data,
  output logic                fifo_wr_en,
  output logic [SAMPLE_W-1:0] fifo_din,
  output logic                fifo_rd_en,
  input  logic [SAMPLE_W-1:0] fifo_dout,
  input  logic                fifo_full,
  input  logic                fifo_empty,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [SAMPLE_W-1:0] m_data,
  output logic                m_first,
  output logic                m_last,
  output logic                ovf,
  input  logic                ovf_clr,
  output logic [DROP_W-1:0]   drop_cnt,
  output logic [LEVEL_W-1:0]  level
);

  localparam int                 IDX_W     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(FRAME_LEN - 1);
  localparam logic [LEVEL_W-1:0] FRAME_LVL = LEVEL_W'(FRAME_LEN);

  frame_state_t     state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic             hs;
  logic             drop;

  assign fifo_wr_en = en && mic_valid && !fifo_full;
  assign fifo_din   = mic_data;
  assign drop       = en && mic_valid && fifo_full;
  assign hs         = m_valid && m_ready;
  assign m_first    = m_valid && (idx == '0);
  assign m_last     = m_valid && (idx == LAST_IDX);

  mic_frame_occ #(.FIFO_DEPTH(FIFO_DEPTH)) u_occ (
    .clk      (clk),
    .rst      (rst),
    .wr       (fifo_wr_en),
    .rd       (fifo_rd_en),
    .drop     (drop),
    .ovf_clr  (ovf_clr),
    .level    (level),
    .ovf      (ovf),
    .drop_cnt (drop_cnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      idx     <= '0;
      m_data  <= '0;
      m_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == WAIT)
        idx <= '0;
      if (state == LOAD) begin
        m_data  <= fifo_dout;
        m_valid <= 1'b1;
      end
      if (hs) begin
        m_valid <= 1'b0;
        idx     <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end
    end
  end

  // en is only consulted between frames, so a frame once started always completes.
  always_comb begin
    state_nxt  = state;
    fifo_rd_en = 1'b0;
    case (state)
      IDLE: if (en) state_nxt = WAIT;
      WAIT: begin
        if (!en)
          state_nxt = IDLE;
        else if (level >= FRAME_LVL)
          state_nxt = RD;
      end
      RD: begin
        if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          state_nxt  = LOAD;
        end
      end
      LOAD: state_nxt = HOLD;
      HOLD: begin
        if (m_ready) begin
          if (idx != LAST_IDX)
            state_nxt = RD;
          else
            state_nxt = en ? WAIT : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mic_frame_ctrl.sv
// Bench for mic_frame_ctrl: behavioural FIFO, sample-order scoreboard and
// drop accounting model, plus directed and randomized scenarios.
`timescale 1ns/1ps
module tb_mic_frame_ctrl;
  import cora_mic_pkg::*;

  localparam int FL    = 64;
  localparam int DEPTH = 128;

  logic        clk = 1'b0, rst = 1'b0, en = 1'b0, mic_valid = 1'b0, m_ready = 1'b0, ovf_clr = 1'b0;
  logic [15:0] mic_data = '0;
  logic        fifo_wr_en, fifo_rd_en, fifo_full, fifo_empty;
  logic [15:0] fifo_din, fifo_dout = '0, m_data, drop_cnt;
  logic        m_valid, m_first, m_last, ovf;
  logic [7:0]  level;

  int total = 0, bad = 0;

  logic [15:0] fq[$];
  int          fifo_cnt = 0;
  bit          stall_empty = 1'b0;

  logic [15:0] eq[$];
  int          frame_cnt = 0, delivered = 0, exp_drop = 0;
  bit          exp_ovf = 1'b0, prev_hold = 1'b0, mon_wr;
  logic [15:0] prev_data = '0, exp_d;

  assign fifo_full  = (fifo_cnt == DEPTH);
  assign fifo_empty = (fifo_cnt == 0) || stall_empty;

  always #5 clk = ~clk;

  mic_frame_ctrl #(.FRAME_LEN(FL), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .en(en), .mic_valid(mic_valid), .mic_data(mic_data),
    .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .fifo_rd_en(fifo_rd_en),
    .fifo_dout(fifo_dout), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_first(m_first),
    .m_last(m_last), .ovf(ovf), .ovf_clr(ovf_clr), .drop_cnt(drop_cnt), .level(level)
  );

  // External FIFO: read data appears one cycle after the read strobe.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      fq.delete();
      fifo_cnt  <= 0;
      fifo_dout <= '0;
    end else begin
      if (fifo_rd_en && fq.size() > 0) begin
        automatic logic [15:0] v = fq.pop_front();
        fifo_dout <= v;
      end
      if (fifo_wr_en && fq.size() < DEPTH) fq.push_back(fifo_din);
      fifo_cnt <= fq.size();
    end
  end

  // Scoreboard: accepted samples must come out in order, framed every FL samples.
  always @(negedge clk) begin
    if (!rst) begin
      eq.delete();
      frame_cnt = 0; exp_drop = 0; exp_ovf = 1'b0; prev_hold = 1'b0;
    end else begin
      mon_wr = en && mic_valid && !fifo_full;
      total++;
      if (fifo_wr_en !== mon_wr || (mon_wr && fifo_din !== mic_data)) begin
        bad++;
        $display("FAIL wr_port: wr_en=%b din=%h required wr_en=%b din=%h", fifo_wr_en, fifo_din, mon_wr, mic_data);
      end
      total++;
      if (level !== 8'(fifo_cnt)) begin
        bad++;
        $display("FAIL level_track: level=%0d required=%0d", level, fifo_cnt);
      end
      total++;
      if (ovf !== exp_ovf || drop_cnt !== 16'(exp_drop)) begin
        bad++;
        $display("FAIL drop_acct: ovf=%b drop_cnt=%0d required ovf=%b drop_cnt=%0d", ovf, drop_cnt, exp_ovf, exp_drop);
      end
      total++;
      if (fifo_rd_en && fifo_empty) begin
        bad++;
        $display("FAIL rd_on_empty: fifo_rd_en=%b required 0 while empty", fifo_rd_en);
      end
      if (prev_hold) begin
        total++;
        if (m_valid !== 1'b1 || m_data !== prev_data) begin
          bad++;
          $display("FAIL hold_stable: m_valid=%b m_data=%h required 1 %h", m_valid, m_data, prev_data);
        end
      end
      if (m_valid && m_ready) begin
        total++;
        if (eq.size() == 0) begin
          bad++;
          $display("FAIL spurious_out: m_data=%h required no output", m_data);
        end else begin
          exp_d = eq.pop_front();
          if (m_data !== exp_d || m_first !== (frame_cnt == 0) || m_last !== (frame_cnt == FL - 1)) begin
            bad++;
            $display("FAIL out_sample: data=%h first=%b last=%b required %h %b %b",
                     m_data, m_first, m_last, exp_d, frame_cnt == 0, frame_cnt == FL - 1);
          end
        end
        frame_cnt = (frame_cnt + 1) % FL;
        delivered++;
      end
      if (mon_wr) eq.push_back(mic_data);
      if (en && mic_valid && fifo_full) begin
        exp_ovf  = 1'b1;
        exp_drop = ovf_clr ? 1 : ((exp_drop == 65535) ? 65535 : exp_drop + 1);
      end else if (ovf_clr) begin
        exp_ovf  = 1'b0;
        exp_drop = 0;
      end
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_n(input int n, input bit seq, input int base);
    for (int i = 0; i < n; i++) begin
      mic_valid = 1'b1;
      mic_data  = seq ? 16'(base + i) : 16'($urandom);
      tick();
    end
    mic_valid = 1'b0;
  endtask

  task automatic wait_deliv(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (delivered >= target) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    tick(); tick();
    @(negedge clk);
    total++;
    if ({m_valid, m_first, m_last, fifo_rd_en, ovf} !== 5'b0 || m_data !== 16'd0 ||
        drop_cnt !== 16'd0 || level !== 8'd0 || dut.state !== IDLE) begin
      bad++;
      $display("FAIL reset_state: v=%b f=%b l=%b rd=%b ovf=%b data=%h drop=%0d level=%0d required all zero/IDLE",
               m_valid, m_first, m_last, fifo_rd_en, ovf, m_data, drop_cnt, level);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_frame();
    int start;
    bit ok;
    en = 1'b1; m_ready = 1'b1;
    start = delivered;
    write_n(FL, 1'b1, 0);
    wait_deliv(start + FL, 400, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL frame_done: delivered=%0d required=%0d", delivered - start, FL);
    end
    tick(); tick();
    total++;
    if (level !== 8'd0 || m_valid !== 1'b0 || frame_cnt != 0) begin
      bad++;
      $display("FAIL frame_end: level=%0d m_valid=%b frame_pos=%0d required 0 0 0", level, m_valid, frame_cnt);
    end
  endtask

  task automatic test_backpressure();
    int start, rd_seen;
    bit ok, found;
    m_ready = 1'b1;
    start = delivered;
    write_n(FL, 1'b1, 0);
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (m_valid && frame_cnt == 5) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL bp_reach: delivered=%0d required to reach sample 5", delivered - start);
    end
    m_ready = 1'b0;
    rd_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fifo_rd_en) rd_seen++;
      total++;
      if (m_valid !== 1'b1 || m_data !== 16'd5) begin
        bad++;
        $display("FAIL bp_hold: m_valid=%b m_data=%0d required 1 5", m_valid, m_data);
      end
    end
    total++;
    if (rd_seen != 0) begin
      bad++;
      $display("FAIL bp_no_read: reads=%0d required 0", rd_seen);
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    wait_deliv(start + FL, 400, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL bp_done: delivered=%0d required=%0d", delivered - start, FL);
    end
  endtask

  task automatic test_en_drop();
    int start;
    bit ok, found;
    en = 1'b1; m_ready = 1'b1;
    start = delivered;
    write_n(FL, 1'b0, 0);
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (delivered - start == 20) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL en_reach: delivered=%0d required 20", delivered - start);
    end
    en = 1'b0;
    wait_deliv(start + FL, 300, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL en_complete: delivered=%0d required=%0d", delivered - start, FL);
    end
    tick(); tick(); tick();
    total++;
    if (dut.state !== IDLE || m_valid !== 1'b0) begin
      bad++;
      $display("FAIL en_idle: state=%0d m_valid=%b required IDLE 0", dut.state, m_valid);
    end
    en = 1'b1;
  endtask

  task automatic test_concurrent();
    int start;
    bit ok, found;
    m_ready = 1'b1;
    start = delivered;
    write_n(FL, 1'b0, 0);
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (fifo_rd_en) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL conc_rd: fifo_rd_en never seen, required a read");
    end
    mic_valid = 1'b1;
    mic_data  = 16'($urandom);
    @(negedge clk);
    total++;
    if (fifo_wr_en !== 1'b1 || fifo_rd_en !== 1'b1 || level !== 8'd64) begin
      bad++;
      $display("FAIL conc_setup: wr=%b rd=%b level=%0d required 1 1 64", fifo_wr_en, fifo_rd_en, level);
    end
    tick();
    mic_valid = 1'b0;
    total++;
    if (level !== 8'd64) begin
      bad++;
      $display("FAIL conc_level: level=%0d required 64", level);
    end
    wait_deliv(start + FL, 400, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL conc_done: delivered=%0d required=%0d", delivered - start, FL);
    end
  endtask

  task automatic test_reset_midframe();
    int start;
    bit ok, found;
    logic [15:0] v;
    m_ready = 1'b1;
    start = delivered;
    write_n(FL - 1, 1'b0, 0);
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (delivered - start == 30) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL rst_reach: delivered=%0d required 30", delivered - start);
    end
    rst = 1'b0;
    #1;
    total++;
    if ({m_valid, m_first, m_last, fifo_rd_en, ovf} !== 5'b0 || m_data !== 16'd0 ||
        drop_cnt !== 16'd0 || level !== 8'd0 || dut.state !== IDLE) begin
      bad++;
      $display("FAIL rst_mid: v=%b f=%b l=%b rd=%b ovf=%b data=%h drop=%0d level=%0d required all zero/IDLE",
               m_valid, m_first, m_last, fifo_rd_en, ovf, m_data, drop_cnt, level);
    end
    tick(); tick();
    rst = 1'b1;
    v = 16'($urandom);
    mic_valid = 1'b1;
    mic_data  = v;
    tick();
    start = delivered;
    write_n(FL - 1, 1'b0, 0);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (m_valid) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    total++;
    if (!found || m_first !== 1'b1 || m_data !== v) begin
      bad++;
      $display("FAIL rst_restart: valid=%b first=%b data=%h required 1 1 %h", m_valid, m_first, m_data, v);
    end
    wait_deliv(start + FL, 400, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL rst_frame: delivered=%0d required=%0d", delivered - start, FL);
    end
  endtask

  task automatic test_overflow();
    int start, supp;
    bit ok;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    stall_empty = 1'b1;
    en = 1'b1; m_ready = 1'b1;
    supp = 0;
    for (int i = 0; i < 130; i++) begin
      mic_valid = 1'b1;
      mic_data  = 16'($urandom);
      @(negedge clk);
      if (!fifo_wr_en) supp++;
      tick();
    end
    mic_valid = 1'b0;
    total++;
    if (level !== 8'd128) begin
      bad++;
      $display("FAIL ovf_level: level=%0d required 128", level);
    end
    total++;
    if (ovf !== 1'b1 || drop_cnt !== 16'd2) begin
      bad++;
      $display("FAIL ovf_flag: ovf=%b drop_cnt=%0d required 1 2", ovf, drop_cnt);
    end
    total++;
    if (supp != 2) begin
      bad++;
      $display("FAIL ovf_suppress: suppressed=%0d required 2", supp);
    end
    total++;
    if (fifo_rd_en !== 1'b0 || dut.state !== RD) begin
      bad++;
      $display("FAIL empty_stall: rd_en=%b state=%0d required 0 RD", fifo_rd_en, dut.state);
    end
    mic_valid = 1'b1; ovf_clr = 1'b1;
    tick();
    mic_valid = 1'b0; ovf_clr = 1'b0;
    total++;
    if (ovf !== 1'b1 || drop_cnt !== 16'd1) begin
      bad++;
      $display("FAIL clr_vs_drop: ovf=%b drop_cnt=%0d required 1 1", ovf, drop_cnt);
    end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    total++;
    if (ovf !== 1'b0 || drop_cnt !== 16'd0) begin
      bad++;
      $display("FAIL ovf_clear: ovf=%b drop_cnt=%0d required 0 0", ovf, drop_cnt);
    end
    stall_empty = 1'b0;
    start = delivered;
    wait_deliv(start + 2 * FL, 1000, ok);
    tick();
    total++;
    if (!ok || level !== 8'd0) begin
      bad++;
      $display("FAIL ovf_drain: delivered=%0d level=%0d required %0d 0", delivered - start, level, 2 * FL);
    end
  endtask

  task automatic test_random();
    en = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      mic_valid = 1'($urandom_range(0, 1));
      mic_data  = 16'($urandom);
      m_ready   = ($urandom_range(0, 3) != 0);
      ovf_clr   = ($urandom_range(0, 63) == 0);
      tick();
    end
    mic_valid = 1'b0; ovf_clr = 1'b0; m_ready = 1'b1;
    repeat (600) tick();
    total++;
    if (level !== 8'(eq.size()) || eq.size() >= FL || m_valid !== 1'b0) begin
      bad++;
      $display("FAIL rand_drain: level=%0d m_valid=%b required level=%0d (<%0d) m_valid=0",
               level, m_valid, eq.size(), FL);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_backpressure();
    test_en_drop();
    test_concurrent();
    test_reset_midframe();
    test_overflow();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
